multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit: main FSM, ALU decode, MUL latency counter
// and combinational datapath strobes derived from state plus live instruction fields.
module multicycle_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int ALUCTRL_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 IsMul,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           FlagW,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 MulBusy
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_MULEX, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       nowrite_q, nowrite_d;

    logic [3:0] cmd;
    logic [2:0] alu_code;
    logic       cmd_ok, is_cmp, is_addsub;
    logic       alu_op, mul_sel, branch;
    logic [2:0] alu_ctl;

    assign cmd = Funct[4:1];

    always_comb begin
        alu_code  = 3'd0;
        cmd_ok    = 1'b1;
        is_cmp    = 1'b0;
        is_addsub = 1'b0;
        case (cmd)
            4'b0100: begin alu_code = 3'd0; is_addsub = 1'b1; end
            4'b0010: begin alu_code = 3'd1; is_addsub = 1'b1; end
            4'b0000: alu_code = 3'd2;
            4'b1100: alu_code = 3'd3;
            4'b0001: alu_code = 3'd4;
            4'b1010: begin alu_code = 3'd1; is_cmp = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= 4'd0;
            nowrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nowrite_q <= nowrite_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nowrite_d = nowrite_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                nowrite_d = (Op == 2'b00) & ~IsMul & is_cmp;
                case (Op)
                    2'b01: state_d = S_MEMADR;
                    2'b00: begin
                        if (IsMul) begin
                            state_d = S_MULEX;
                            cnt_d   = MUL_LOAD;
                        end else if (!cmd_ok) state_d = S_FETCH;
                        else if (Funct[5])    state_d = S_EXECI;
                        else                  state_d = S_EXECR;
                    end
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            S_MULEX: begin
                // counter holds the number of MULEX cycles still to follow
                if (cnt_q == 4'd0) state_d = S_ALUWB;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        FlagW     = 2'b00;
        alu_op    = 1'b0;
        mul_sel   = 1'b0;
        branch    = 1'b0;
        MulBusy   = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1; NextPC = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB:  begin ResultSrc = 2'b01; RegW = 1'b1; end
            S_MEMWR:  begin AdrSrc = 1'b1; MemW = 1'b1; end
            S_EXECR,
            S_EXECI: begin
                ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_op  = 1'b1;
                FlagW   = is_cmp ? 2'b11 : {Funct[0], Funct[0] & is_addsub};
            end
            S_MULEX: begin
                alu_op  = 1'b1;
                mul_sel = 1'b1;
                MulBusy = 1'b1;
                FlagW   = {Funct[0] & (cnt_q == 4'd0), 1'b0};
            end
            S_ALUWB:  RegW = ~nowrite_q;
            S_BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_ctl    = !alu_op ? 3'd0 : (mul_sel ? 3'd5 : alu_code);
    assign ALUControl = ALUCTRL_W'(alu_ctl);
    assign PCS        = ((Rd == 4'hF) & RegW) | branch;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01) & ~Funct[0], Op == 2'b10};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output trace and compared on two instances (MUL latency 3 and 1).
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IsMul;

    logic       PCS_0, NextPC_0, RegW_0, MemW_0, IRWrite_0, AdrSrc_0, MulBusy_0;
    logic [1:0] ResultSrc_0, ALUSrcA_0, ALUSrcB_0, ImmSrc_0, RegSrc_0, FlagW_0;
    logic [2:0] ALUControl_0;
    logic       PCS_1, NextPC_1, RegW_1, MemW_1, IRWrite_1, AdrSrc_1, MulBusy_1;
    logic [1:0] ResultSrc_1, ALUSrcA_1, ALUSrcB_1, ImmSrc_1, RegSrc_1, FlagW_1;
    logic [2:0] ALUControl_1;

    multicycle_ctrl #(.MUL_LATENCY(3), .ALUCTRL_W(3)) u_dut0 (
        .clk(clk), .reset(rst0), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
        .PCS(PCS_0), .NextPC(NextPC_0), .RegW(RegW_0), .MemW(MemW_0),
        .IRWrite(IRWrite_0), .AdrSrc(AdrSrc_0), .ResultSrc(ResultSrc_0),
        .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0), .ImmSrc(ImmSrc_0),
        .RegSrc(RegSrc_0), .FlagW(FlagW_0), .ALUControl(ALUControl_0),
        .MulBusy(MulBusy_0));

    multicycle_ctrl #(.MUL_LATENCY(1), .ALUCTRL_W(3)) u_dut1 (
        .clk(clk), .reset(rst1), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
        .PCS(PCS_1), .NextPC(NextPC_1), .RegW(RegW_1), .MemW(MemW_1),
        .IRWrite(IRWrite_1), .AdrSrc(AdrSrc_1), .ResultSrc(ResultSrc_1),
        .ALUSrcA(ALUSrcA_1), .ALUSrcB(ALUSrcB_1), .ImmSrc(ImmSrc_1),
        .RegSrc(RegSrc_1), .FlagW(FlagW_1), .ALUControl(ALUControl_1),
        .MulBusy(MulBusy_1));

    logic [21:0] obs0, obs1;
    assign obs0 = {PCS_0, NextPC_0, RegW_0, MemW_0, IRWrite_0, AdrSrc_0, ResultSrc_0,
                   ALUSrcA_0, ALUSrcB_0, ImmSrc_0, RegSrc_0, FlagW_0, ALUControl_0, MulBusy_0};
    assign obs1 = {PCS_1, NextPC_1, RegW_1, MemW_1, IRWrite_1, AdrSrc_1, ResultSrc_1,
                   ALUSrcA_1, ALUSrcB_1, ImmSrc_1, RegSrc_1, FlagW_1, ALUControl_1, MulBusy_1};

    int n_cmp = 0;
    int n_err = 0;
    logic [21:0] exp_q[$];

    task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h (Op=%b Funct=%b Rd=%h IsMul=%b)",
                     tag, got, exp, Op, Funct, Rd, IsMul);
        end
    endtask

    // Expected output word for one cycle, given that cycle's strobes and selects.
    function automatic logic [21:0] v(input logic npc, irw, regw, memw, adr, br,
                                      input logic [1:0] rs, a, b, fw,
                                      input logic [2:0] ac, input logic mb);
        logic pcs;
        pcs = ((Rd == 4'hF) && regw) || br;
        return {pcs, npc, regw, memw, irw, adr, rs, a, b, Op,
                {(Op == 2'b01) && !Funct[0], Op == 2'b10}, fw, ac, mb};
    endfunction

    // Whole-instruction trace from FETCH up to the last cycle before the next FETCH.
    task automatic build(input int lat);
        logic       s, ok, cmp, addsub;
        logic [2:0] code;
        exp_q.delete();
        s = Funct[0];
        exp_q.push_back(v(1, 1, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 2'd0, 3'd0, 0));
        exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 2'd0, 3'd0, 0));
        if (Op == 2'b01) begin
            exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0, 0));
            if (s) begin
                exp_q.push_back(v(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
                exp_q.push_back(v(0, 0, 1, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end else
                exp_q.push_back(v(0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
        end else if (Op == 2'b10) begin
            exp_q.push_back(v(0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd1, 2'd0, 3'd0, 0));
        end else if (Op == 2'b00 && IsMul) begin
            for (int i = 0; i < lat; i++)
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0,
                                  (i == lat - 1 && s) ? 2'b10 : 2'b00, 3'd5, 1));
            exp_q.push_back(v(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
        end else if (Op == 2'b00) begin
            ok = 1; cmp = 0; addsub = 0; code = 0;
            case (Funct[4:1])
                4'b0100: begin code = 0; addsub = 1; end
                4'b0010: begin code = 1; addsub = 1; end
                4'b0000: code = 2;
                4'b1100: code = 3;
                4'b0001: code = 4;
                4'b1010: begin code = 1; cmp = 1; end
                default: ok = 0;
            endcase
            if (ok) begin
                exp_q.push_back(v(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, Funct[5] ? 2'd1 : 2'd0,
                                  cmp ? 2'b11 : {s, s & addsub}, code, 0));
                exp_q.push_back(v(0, 0, !cmp, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
        end
    endtask

    // Entered and left just after a rising edge with the selected DUT in FETCH.
    task automatic do_instr(input int k, input int lat, input logic [1:0] op,
                            input logic [5:0] f, input logic [3:0] rd, input logic m,
                            input string tag);
        Op = op; Funct = f; Rd = rd; IsMul = m;
        build(lat);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk(tag, (k == 1) ? obs1 : obs0, exp_q[i]);
            @(posedge clk); #1;
        end
    endtask

    // Runs the first n cycles, then asserts reset during cycle n.
    task automatic reset_at(input int k, input int lat, input logic [1:0] op,
                            input logic [5:0] f, input logic m, input int n,
                            input string tag);
        Op = op; Funct = f; Rd = 4'hF; IsMul = m;
        build(lat);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            chk(tag, (k == 1) ? obs1 : obs0, exp_q[i]);
            if (i == n) begin
                if (k == 1) rst1 = 1'b1; else rst0 = 1'b1;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_after_reset"}, (k == 1) ? obs1 : obs0, exp_q[0]);
        @(posedge clk); #1;
        if (k == 1) rst1 = 1'b0; else rst0 = 1'b0;
    endtask

    task automatic random_run(input int k, input int lat, input int count);
        logic [3:0] cmds[6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};
        logic [5:0] f;
        logic [3:0] rd;
        for (int i = 0; i < count; i++) begin
            f = 6'($urandom);
            if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            do_instr(k, lat, 2'($urandom_range(0, 3)), f, rd, $urandom_range(0, 2) == 0,
                     "rand");
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        Op = 2'b11; Funct = 6'd0; Rd = 4'hF; IsMul = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        build(3);
        chk("reset0", obs0, exp_q[0]);
        chk("reset1", obs1, exp_q[0]);
        @(posedge clk); #1;
        rst0 = 1'b0;

        do_instr(0, 3, 2'b00, 6'b0_0100_1, 4'h1, 1'b0, "add_s");
        do_instr(0, 3, 2'b01, 6'b0_0000_1, 4'h2, 1'b0, "ldr");
        do_instr(0, 3, 2'b01, 6'b0_0000_0, 4'h2, 1'b0, "str");
        do_instr(0, 3, 2'b00, 6'b0_0000_1, 4'h3, 1'b1, "mul3_s");
        do_instr(0, 3, 2'b00, 6'b0_1010_0, 4'h4, 1'b0, "cmp");
        do_instr(0, 3, 2'b00, 6'b1_0100_0, 4'hF, 1'b0, "add_pc");
        do_instr(0, 3, 2'b10, 6'b0_0000_0, 4'h0, 1'b0, "branch");
        do_instr(0, 3, 2'b11, 6'b0_0000_0, 4'hF, 1'b0, "op11");
        do_instr(0, 3, 2'b00, 6'b0_1111_1, 4'hF, 1'b0, "unsup");
        reset_at(0, 3, 2'b00, 6'b0_0000_1, 1'b1, 3, "rst_mulex");
        reset_at(0, 3, 2'b01, 6'b0_0000_1, 1'b0, 3, "rst_memrd");
        do_instr(0, 3, 2'b00, 6'b0_1100_0, 4'h5, 1'b0, "orr_post_rst");
        random_run(0, 3, 150);

        rst0 = 1'b1;
        rst1 = 1'b0;
        do_instr(1, 1, 2'b00, 6'b0_0000_1, 4'hF, 1'b1, "mul1_s");
        do_instr(1, 1, 2'b00, 6'b0_0001_0, 4'h6, 1'b1, "mul1");
        random_run(1, 1, 150);

        @(negedge clk);
        build(1);
        chk("final_fetch", obs1, exp_q[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
